// File: rtl/gecko_mem_arbiter_pkg.sv
// Shared types for the gecko memory arbiter: the request source tag carried
// through the in-flight FIFO and the request payload bundle that gets muxed.
package gecko_mem_arbiter_pkg;

  localparam int GECKO_MEM_ADDR_W = 32;
  localparam int GECKO_MEM_DATA_W = 32;
  localparam int GECKO_MEM_MASK_W = GECKO_MEM_DATA_W / 8;

  typedef enum logic [0:0] {
    GECKO_MEM_SRC_INST,
    GECKO_MEM_SRC_DATA
  } gecko_mem_source_t;

  typedef struct packed {
    logic [GECKO_MEM_ADDR_W-1:0] addr;
    logic [GECKO_MEM_DATA_W-1:0] data;
    logic [GECKO_MEM_MASK_W-1:0] write_enable;
    logic                        read_write;
  } gecko_mem_req_t;

  function automatic gecko_mem_source_t gecko_mem_other(input gecko_mem_source_t src);
    return (src == GECKO_MEM_SRC_INST) ? GECKO_MEM_SRC_DATA : GECKO_MEM_SRC_INST;
  endfunction

endpackage

// File: rtl/gecko_mem_arbiter_tag_fifo.sv
// Ordered record of which requester owns each in-flight memory transaction.
// Pointers wrap naturally (power-of-two depth); count is one bit wider.
module gecko_mem_arbiter_tag_fifo
  import gecko_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  gecko_mem_source_t          push_src,
  input  logic                       pop,
  output gecko_mem_source_t          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  gecko_mem_source_t entries [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_src;
  end

  assign head  = entries[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/gecko_mem_arbiter.sv
// Shares one memory port between the gecko fetch and load/store streams,
// steering in-order memory results back to whichever stream issued them.
module gecko_mem_arbiter
  import gecko_mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_PRIORITY   = 1
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        inst_request_valid,
  output logic                        inst_request_ready,
  input  logic [GECKO_MEM_ADDR_W-1:0] inst_request_addr,
  input  logic [GECKO_MEM_DATA_W-1:0] inst_request_data,
  input  logic [GECKO_MEM_MASK_W-1:0] inst_request_write_enable,
  input  logic                        inst_request_read_write,
  output logic                        inst_result_valid,
  input  logic                        inst_result_ready,
  output logic [GECKO_MEM_DATA_W-1:0] inst_result_data,

  input  logic                        data_request_valid,
  output logic                        data_request_ready,
  input  logic [GECKO_MEM_ADDR_W-1:0] data_request_addr,
  input  logic [GECKO_MEM_DATA_W-1:0] data_request_data,
  input  logic [GECKO_MEM_MASK_W-1:0] data_request_write_enable,
  input  logic                        data_request_read_write,
  output logic                        data_result_valid,
  input  logic                        data_result_ready,
  output logic [GECKO_MEM_DATA_W-1:0] data_result_data,

  output logic                        mem_request_valid,
  input  logic                        mem_request_ready,
  output logic [GECKO_MEM_ADDR_W-1:0] mem_request_addr,
  output logic [GECKO_MEM_DATA_W-1:0] mem_request_data,
  output logic [GECKO_MEM_MASK_W-1:0] mem_request_write_enable,
  output logic                        mem_request_read_write,
  input  logic                        mem_result_valid,
  output logic                        mem_result_ready,
  input  logic [GECKO_MEM_DATA_W-1:0] mem_result_data,

  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

  gecko_mem_source_t grant;
  gecko_mem_source_t last_grant;
  gecko_mem_source_t locked_src;
  gecko_mem_source_t head;
  logic              locked;
  logic              granted_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_full_block;
  logic              push;
  logic              pop;
  gecko_mem_req_t    inst_req;
  gecko_mem_req_t    data_req;
  gecko_mem_req_t    mem_req;

  // A locked grant sticks to the stalled requester so the memory never sees
  // its payload change mid-offer; otherwise arbitrate by priority or fairness.
  always_comb begin
    grant = GECKO_MEM_SRC_INST;
    if (locked) begin
      grant = locked_src;
    end else if (inst_request_valid && data_request_valid) begin
      if (DATA_PRIORITY != 0) grant = GECKO_MEM_SRC_DATA;
      else                    grant = gecko_mem_other(last_grant);
    end else if (data_request_valid) begin
      grant = GECKO_MEM_SRC_DATA;
    end
  end

  assign inst_req = '{addr: inst_request_addr, data: inst_request_data,
                      write_enable: inst_request_write_enable,
                      read_write: inst_request_read_write};
  assign data_req = '{addr: data_request_addr, data: data_request_data,
                      write_enable: data_request_write_enable,
                      read_write: data_request_read_write};
  assign mem_req  = (grant == GECKO_MEM_SRC_DATA) ? data_req : inst_req;

  assign granted_valid   = (grant == GECKO_MEM_SRC_DATA) ? data_request_valid : inst_request_valid;
  assign pop             = mem_result_valid && mem_result_ready;
  assign fifo_full_block = fifo_full && !pop;
  assign push            = mem_request_valid && mem_request_ready;

  assign mem_request_valid        = rst && granted_valid && !fifo_full_block;
  assign mem_request_addr         = mem_req.addr;
  assign mem_request_data         = mem_req.data;
  assign mem_request_write_enable = mem_req.write_enable;
  assign mem_request_read_write   = mem_req.read_write;

  assign inst_request_ready = rst && (grant == GECKO_MEM_SRC_INST) && mem_request_ready && !fifo_full_block;
  assign data_request_ready = rst && (grant == GECKO_MEM_SRC_DATA) && mem_request_ready && !fifo_full_block;

  // Results come back in request order, so the FIFO head names the owner.
  assign inst_result_valid = !fifo_empty && (head == GECKO_MEM_SRC_INST) && mem_result_valid;
  assign data_result_valid = !fifo_empty && (head == GECKO_MEM_SRC_DATA) && mem_result_valid;
  assign mem_result_ready  = !fifo_empty &&
                             ((head == GECKO_MEM_SRC_INST) ? inst_result_ready : data_result_ready);
  assign inst_result_data  = mem_result_data;
  assign data_result_data  = mem_result_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GECKO_MEM_SRC_DATA;
      locked     <= 1'b0;
      locked_src <= GECKO_MEM_SRC_INST;
    end else begin
      if (push) last_grant <= grant;
      locked     <= mem_request_valid && !mem_request_ready;
      locked_src <= grant;
    end
  end

  gecko_mem_arbiter_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_src (grant),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding)
  );

  no_result_when_empty: assert property (@(posedge clk) disable iff (!rst)
                                         !(mem_result_valid && fifo_empty));

endmodule

// File: tb/tb_gecko_mem_arbiter.sv
// Directed, table-driven bench for gecko_mem_arbiter: one data-priority
// instance and one round-robin instance, plus an async-reset sequence.
module tb_gecko_mem_arbiter;

  typedef struct {
    bit          rr;
    bit          iv;
    logic [31:0] ia;
    bit          dv;
    logic [31:0] da;
    bit          mrdy;
    bit          rv;
    logic [31:0] rdata;
    bit          eir;
    bit          edr;
    bit          emv;
    bit          eg;
    bit          eiv;
    bit          edv;
    int          eout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iv = 1'b0, dv = 1'b0;
  logic [31:0] ia = '0, da = '0;
  logic        mrdy = 1'b0, rv = 1'b0, mrdy_rr = 1'b0, rv_rr = 1'b0;
  logic [31:0] rdata = '0;
  logic        inst_res_ready = 1'b1, data_res_ready = 1'b1;
  logic [31:0] dwdata;

  logic        m_irdy, m_drdy, m_iresv, m_dresv, m_mv, m_mrw, m_mresrdy;
  logic [31:0] m_ires, m_dres, m_maddr, m_mdata;
  logic [3:0]  m_mwe;
  logic [2:0]  m_out;
  logic        r_irdy, r_drdy, r_iresv, r_dresv, r_mv, r_mrw, r_mresrdy;
  logic [31:0] r_ires, r_dres, r_maddr, r_mdata;
  logic [3:0]  r_mwe;
  logic [2:0]  r_out;

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[$];

  assign dwdata = {16'hD0D0, da[15:0]};

  always #5 clk = ~clk;

  gecko_mem_arbiter #(.MAX_OUTSTANDING(4), .DATA_PRIORITY(1)) dut_main (
    .clk(clk), .rst(rst),
    .inst_request_valid(iv), .inst_request_ready(m_irdy), .inst_request_addr(ia),
    .inst_request_data(32'h0), .inst_request_write_enable(4'h0), .inst_request_read_write(1'b0),
    .inst_result_valid(m_iresv), .inst_result_ready(inst_res_ready), .inst_result_data(m_ires),
    .data_request_valid(dv), .data_request_ready(m_drdy), .data_request_addr(da),
    .data_request_data(dwdata), .data_request_write_enable(4'hF), .data_request_read_write(1'b1),
    .data_result_valid(m_dresv), .data_result_ready(data_res_ready), .data_result_data(m_dres),
    .mem_request_valid(m_mv), .mem_request_ready(mrdy), .mem_request_addr(m_maddr),
    .mem_request_data(m_mdata), .mem_request_write_enable(m_mwe), .mem_request_read_write(m_mrw),
    .mem_result_valid(rv), .mem_result_ready(m_mresrdy), .mem_result_data(rdata),
    .outstanding(m_out)
  );

  gecko_mem_arbiter #(.MAX_OUTSTANDING(4), .DATA_PRIORITY(0)) dut_rr (
    .clk(clk), .rst(rst),
    .inst_request_valid(iv), .inst_request_ready(r_irdy), .inst_request_addr(ia),
    .inst_request_data(32'h0), .inst_request_write_enable(4'h0), .inst_request_read_write(1'b0),
    .inst_result_valid(r_iresv), .inst_result_ready(inst_res_ready), .inst_result_data(r_ires),
    .data_request_valid(dv), .data_request_ready(r_drdy), .data_request_addr(da),
    .data_request_data(dwdata), .data_request_write_enable(4'hF), .data_request_read_write(1'b1),
    .data_result_valid(r_dresv), .data_result_ready(data_res_ready), .data_result_data(r_dres),
    .mem_request_valid(r_mv), .mem_request_ready(mrdy_rr), .mem_request_addr(r_maddr),
    .mem_request_data(r_mdata), .mem_request_write_enable(r_mwe), .mem_request_read_write(r_mrw),
    .mem_result_valid(rv_rr), .mem_result_ready(r_mresrdy), .mem_result_data(rdata),
    .outstanding(r_out)
  );

  function automatic vec_t mk(bit rr_, bit iv_, logic [31:0] ia_, bit dv_, logic [31:0] da_,
                              bit mrdy_, bit rv_, logic [31:0] rdata_, bit eir_, bit edr_,
                              bit emv_, bit eg_, bit eiv_, bit edv_, int eout_);
    vec_t v;
    v.rr = rr_; v.iv = iv_; v.ia = ia_; v.dv = dv_; v.da = da_;
    v.mrdy = mrdy_; v.rv = rv_; v.rdata = rdata_;
    v.eir = eir_; v.edr = edr_; v.emv = emv_; v.eg = eg_;
    v.eiv = eiv_; v.edv = edv_; v.eout = eout_;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic        irdy, drdy, iresv, dresv, mv, mrw;
    logic [31:0] ires, dres, maddr, mdata;
    logic [3:0]  mwe;
    logic [2:0]  outs;
    string       p;
    p = $sformatf("%s%0d", v.rr ? "rr" : "v", idx);
    if (v.rr) begin
      irdy = r_irdy; drdy = r_drdy; iresv = r_iresv; dresv = r_dresv; mv = r_mv; mrw = r_mrw;
      ires = r_ires; dres = r_dres; maddr = r_maddr; mdata = r_mdata; mwe = r_mwe; outs = r_out;
    end else begin
      irdy = m_irdy; drdy = m_drdy; iresv = m_iresv; dresv = m_dresv; mv = m_mv; mrw = m_mrw;
      ires = m_ires; dres = m_dres; maddr = m_maddr; mdata = m_mdata; mwe = m_mwe; outs = m_out;
    end
    checkVal({p, ".inst_req_ready"}, 32'(irdy), 32'(v.eir));
    checkVal({p, ".data_req_ready"}, 32'(drdy), 32'(v.edr));
    checkVal({p, ".mem_req_valid"}, 32'(mv), 32'(v.emv));
    if (v.emv) begin
      checkVal({p, ".mem_addr"}, maddr, v.eg ? v.da : v.ia);
      checkVal({p, ".mem_data"}, mdata, v.eg ? {16'hD0D0, v.da[15:0]} : 32'h0);
      checkVal({p, ".mem_we"}, 32'(mwe), v.eg ? 32'hF : 32'h0);
      checkVal({p, ".mem_rw"}, 32'(mrw), 32'(v.eg));
    end
    checkVal({p, ".inst_res_valid"}, 32'(iresv), 32'(v.eiv));
    checkVal({p, ".data_res_valid"}, 32'(dresv), 32'(v.edv));
    if (v.eiv) checkVal({p, ".inst_res_data"}, ires, v.rdata);
    if (v.edv) checkVal({p, ".data_res_data"}, dres, v.rdata);
    checkVal({p, ".outstanding"}, 32'(outs), 32'(v.eout));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    iv = v.iv; ia = v.ia; dv = v.dv; da = v.da; rdata = v.rdata;
    if (v.rr) begin
      mrdy_rr = v.mrdy; rv_rr = v.rv; mrdy = 1'b0; rv = 1'b0;
    end else begin
      mrdy = v.mrdy; rv = v.rv; mrdy_rr = 1'b0; rv_rr = 1'b0;
    end
    @(negedge clk);
    checkOutput(idx, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Eight back-to-back fetches, memory latency 1, data = 0x100 + addr.
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 1, 32'(4*k), 0, 0, 1, k > 0, k > 0 ? 32'(32'h100 + 4*(k-1)) : 32'h0,
                        1, 0, 1, 0, k > 0, 0, k > 0 ? 1 : 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h11C, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Conflict with data priority: data takes every cycle until it drops.
    for (int c = 0; c < 4; c++)
      vecs.push_back(mk(0, 1, 32'h40, 1, 32'(32'h80 + 4*c), 1, c > 0,
                        c > 0 ? 32'(32'h180 + 4*(c-1)) : 32'h0, 0, 1, 1, 1, 0, c > 0, c > 0 ? 1 : 0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 0, 1, 1, 32'h18C, 1, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h140, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Grant lock: stalled inst offer keeps the port even though data would win.
    vecs.push_back(mk(0, 1, 32'h48, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h48, 1, 32'hA0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h48, 1, 32'hA0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h48, 1, 32'hA0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hA0, 1, 1, 32'h148, 0, 1, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1A0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Full FIFO: four accepted, fifth blocked until a result pops that cycle.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 32'(32'h200 + 4*k), 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, k));
    vecs.push_back(mk(0, 1, 32'h210, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 32'h210, 0, 0, 1, 1, 32'h300, 1, 0, 1, 0, 1, 0, 4));
    for (int j = 0; j < 4; j++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'(32'h304 + 4*j), 0, 0, 0, 0, 1, 0, 4 - j));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Round-robin instance: both always valid, grants alternate from INST.
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1, 1, 32'h30, 1, 32'hB0, 1, k > 0,
                        k == 0 ? 32'h0 : ((k % 2) == 1 ? 32'h130 : 32'h1B0),
                        (k % 2) == 0, (k % 2) == 1, 1, (k % 2) == 1,
                        (k % 2) == 1, k > 0 && (k % 2) == 0, k > 0 ? 1 : 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h1B0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state, with a fetch already pending to show request gating.
    iv = 1'b1; ia = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset.outstanding", 32'(m_out), 32'h0);
    checkVal("reset.rr_outstanding", 32'(r_out), 32'h0);
    checkVal("reset.mem_req_valid", 32'(m_mv), 32'h0);
    checkVal("reset.inst_req_ready", 32'(m_irdy), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    // Async reset with three fetches in flight.
    for (int k = 0; k < 3; k++)
      applyStimulus(100 + k, mk(0, 1, 32'(32'h50 + 4*k), 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, k));
    iv = 1'b1; ia = 32'h5C; mrdy = 1'b1; rv = 1'b0;
    #2;
    checkVal("arst.before", 32'(m_out), 32'h3);
    rst = 1'b0;
    #1;
    checkVal("arst.outstanding", 32'(m_out), 32'h0);
    checkVal("arst.mem_req_valid", 32'(m_mv), 32'h0);
    checkVal("arst.inst_req_ready", 32'(m_irdy), 32'h0);
    checkVal("arst.data_req_ready", 32'(m_drdy), 32'h0);
    checkVal("arst.mem_res_ready", 32'(m_mresrdy), 32'h0);
    checkVal("arst.inst_res_valid", 32'(m_iresv), 32'h0);
    checkVal("arst.data_res_valid", 32'(m_dresv), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(200, mk(0, 1, 32'h60, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    applyStimulus(201, mk(0, 0, 0, 0, 0, 0, 1, 32'h160, 0, 0, 0, 0, 1, 0, 1));
    applyStimulus(202, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
